// File: rtl/vram_arbiter_if.sv
// VRAM arbiter bus bundle: three requester ports plus the VRAM device pins.
//
// Handshake: each requester raises req with a stable address (and write flag
// and data for the CPU) and holds it until it sees its ack. The ack is a
// single-cycle pulse, and rdata is valid while ack is high. The requester
// drops req in the ack cycle, so the arbiter never sees a stale request.
// A requester that lowers req mid-access still receives its ack.
interface vram_arbiter_if;
    logic        cpu_req;
    logic        cpu_wr;
    logic [12:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;

    logic        dma_req;
    logic [12:0] dma_addr;
    logic        dma_ack;
    logic [7:0]  dma_rdata;

    logic        ppu_req;
    logic [12:0] ppu_addr;
    logic        ppu_ack;
    logic [7:0]  ppu_rdata;

    logic        ppu_mode3;

    logic [12:0] ma;
    logic [7:0]  md_in;
    logic [7:0]  md_out;
    logic        md_oe;
    logic        mcs;
    logic        moe;
    logic        mwr;

    // Arbiter view
    modport slave (
        input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        input  dma_req, dma_addr,
        output dma_ack, dma_rdata,
        input  ppu_req, ppu_addr,
        output ppu_ack, ppu_rdata,
        input  ppu_mode3,
        output ma, md_out, md_oe, mcs, moe, mwr,
        input  md_in
    );

    // Requester / memory-model view
    modport master (
        output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        output dma_req, dma_addr,
        input  dma_ack, dma_rdata,
        output ppu_req, ppu_addr,
        input  ppu_ack, ppu_rdata,
        output ppu_mode3,
        input  ma, md_out, md_oe, mcs, moe, mwr,
        output md_in
    );
endinterface

// File: rtl/vram_arbiter.sv
// VRAM arbiter: fixed priority PPU > DMA > CPU, two-cycle ADDR/DATA access,
// CPU/DMA lockout during PPU mode 3 (dummy BLOCK1/BLOCK2 access returning 0xFF).
// All bus outputs are registered and derived from the next-state values.
module vram_arbiter (
    input  logic                 clk,
    input  logic                 reset,
    vram_arbiter_if.slave        bus,
    output logic [2:0]           dbg_state
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADDR   = 3'd1,
        S_DATA   = 3'd2,
        S_BLOCK1 = 3'd3,
        S_BLOCK2 = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        ID_CPU = 2'd0,
        ID_DMA = 2'd1,
        ID_PPU = 2'd2
    } req_id_t;

    state_t      state_q, state_d;
    req_id_t     id_q, id_d;
    logic [12:0] addr_q, addr_d;
    logic        wr_q, wr_d;
    logic [7:0]  wdata_q, wdata_d;

    logic        mcs_q, mcs_d, moe_q, moe_d, mwr_q, mwr_d, md_oe_q, md_oe_d;
    logic [12:0] ma_q, ma_d;
    logic [7:0]  md_out_q, md_out_d;
    logic        cpu_ack_q, cpu_ack_d, dma_ack_q, dma_ack_d, ppu_ack_q, ppu_ack_d;
    logic [7:0]  cpu_rdata_q, cpu_rdata_d, dma_rdata_q, dma_rdata_d;
    logic [7:0]  ppu_rdata_q, ppu_rdata_d;

    logic        arb_en, finishing;
    logic        cpu_cand, dma_cand, ppu_cand;
    logic [7:0]  done_data;

    // Next-state, grant, completion and registered-output computation
    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        addr_d      = addr_q;
        wr_d        = wr_q;
        wdata_d     = wdata_q;
        mcs_d       = 1'b0;
        moe_d       = 1'b0;
        mwr_d       = 1'b0;
        md_oe_d     = 1'b0;
        ma_d        = ma_q;
        md_out_d    = md_out_q;
        cpu_ack_d   = 1'b0;
        dma_ack_d   = 1'b0;
        ppu_ack_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        ppu_rdata_d = ppu_rdata_q;

        finishing = (state_q == S_DATA) || (state_q == S_BLOCK2);
        arb_en    = finishing || (state_q == S_IDLE);

        // The requester being completed cannot see its ack until next cycle,
        // so its still-high req is ignored at this edge to avoid a repeat.
        ppu_cand = bus.ppu_req && !(finishing && id_q == ID_PPU);
        dma_cand = bus.dma_req && !(finishing && id_q == ID_DMA);
        cpu_cand = bus.cpu_req && !(finishing && id_q == ID_CPU);

        // Completion: pulse ack and capture read data (0xFF when locked out)
        done_data = (state_q == S_DATA) ? bus.md_in : 8'hFF;
        if (finishing) begin
            case (id_q)
                ID_PPU: begin
                    ppu_ack_d = 1'b1;
                    if (!wr_q) ppu_rdata_d = done_data;
                end
                ID_DMA: begin
                    dma_ack_d = 1'b1;
                    if (!wr_q) dma_rdata_d = done_data;
                end
                default: begin
                    cpu_ack_d = 1'b1;
                    if (!wr_q) cpu_rdata_d = done_data;
                end
            endcase
        end

        case (state_q)
            S_ADDR:   state_d = S_DATA;
            S_BLOCK1: state_d = S_BLOCK2;
            default:  state_d = S_IDLE;
        endcase

        // Fixed-priority grant; the lockout decision is frozen at the grant
        if (arb_en) begin
            if (ppu_cand) begin
                id_d    = ID_PPU;
                addr_d  = bus.ppu_addr;
                wr_d    = 1'b0;
                state_d = S_ADDR;
            end else if (dma_cand) begin
                id_d    = ID_DMA;
                addr_d  = bus.dma_addr;
                wr_d    = 1'b0;
                state_d = bus.ppu_mode3 ? S_BLOCK1 : S_ADDR;
            end else if (cpu_cand) begin
                id_d    = ID_CPU;
                addr_d  = bus.cpu_addr;
                wr_d    = bus.cpu_wr;
                wdata_d = bus.cpu_wdata;
                state_d = bus.ppu_mode3 ? S_BLOCK1 : S_ADDR;
            end
        end

        // VRAM pins for the cycle being entered
        case (state_d)
            S_ADDR: begin
                mcs_d   = 1'b1;
                ma_d    = addr_d;
                moe_d   = !wr_d;
                md_oe_d = wr_d;
                if (wr_d) md_out_d = wdata_d;
            end
            S_DATA: begin
                mcs_d   = 1'b1;
                moe_d   = !wr_d;
                mwr_d   = wr_d;
                md_oe_d = wr_d;
            end
            default: ;
        endcase
    end

    // State and output registers; reset aborts any access in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            id_q        <= ID_CPU;
            addr_q      <= '0;
            wr_q        <= 1'b0;
            wdata_q     <= '0;
            mcs_q       <= 1'b0;
            moe_q       <= 1'b0;
            mwr_q       <= 1'b0;
            md_oe_q     <= 1'b0;
            ma_q        <= '0;
            md_out_q    <= '0;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
            ppu_ack_q   <= 1'b0;
            cpu_rdata_q <= 8'hFF;
            dma_rdata_q <= 8'hFF;
            ppu_rdata_q <= 8'hFF;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            addr_q      <= addr_d;
            wr_q        <= wr_d;
            wdata_q     <= wdata_d;
            mcs_q       <= mcs_d;
            moe_q       <= moe_d;
            mwr_q       <= mwr_d;
            md_oe_q     <= md_oe_d;
            ma_q        <= ma_d;
            md_out_q    <= md_out_d;
            cpu_ack_q   <= cpu_ack_d;
            dma_ack_q   <= dma_ack_d;
            ppu_ack_q   <= ppu_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
            ppu_rdata_q <= ppu_rdata_d;
        end
    end

    assign bus.mcs       = mcs_q;
    assign bus.moe       = moe_q;
    assign bus.mwr       = mwr_q;
    assign bus.md_oe     = md_oe_q;
    assign bus.ma        = ma_q;
    assign bus.md_out    = md_out_q;
    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.dma_ack   = dma_ack_q;
    assign bus.ppu_ack   = ppu_ack_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.dma_rdata = dma_rdata_q;
    assign bus.ppu_rdata = ppu_rdata_q;
    assign dbg_state     = state_q;
endmodule
